enoc_inject_sched: RTL and testbench
====================================

// Module: enoc_inject_sched
// PURPOSE
// - Per-node injection scheduler: shares one ENoC network input port (pkt_in[i]/net_full[i]) between N_SRC traffic sources.
// - Round-robin with bounded bursts, one-entry output register, obeys net_full backpressure, reports stall time.
// - One instance per node, sits between the NetEmulation source queues and the network wrapper.
// PARAMETERS
// - N_SRC     4  number of requesting sources (>=2)
// - MAX_BURST 8  max consecutive grants to one source while another source is requesting (>=1)
// - CNT_W     8  width of the saturating stall counter
// PORTS
// - clk        in   1               clock; all state updates on posedge
// - rst        in   1               synchronous, active-high reset
// - src_pkt    in   packet_t[N_SRC] per-source packet; its .valid field is ignored
// - src_val    in   N_SRC           source i has a packet on src_pkt[i]
// - src_rdy    out  N_SRC           grant/accept, at most one bit set; transfer = src_val[i] & src_rdy[i]
// - net_full   in   1               network input not accepting this cycle
// - pkt_out    out  packet_t        to network pkt_in; .valid set while the register holds a packet
// - grant_id   out  $clog2(N_SRC)   source index of the packet held in pkt_out
// - stall_cnt  out  CNT_W           consecutive cycles the current packet has waited on net_full, saturating
// BEHAVIOUR
// - Reset values (next posedge with rst=1): pkt_out='0, grant_id=0, stall_cnt=0, rr_ptr=0, burst_cnt=0, state=EMPTY.
//   Reset has priority over every other event. A held packet is dropped. src_rdy=0 while rst=1.
// - FSM: EMPTY (no packet held) and FULL (pkt_out.valid=1).
// - Network accepts: in FULL, net_full=0 consumes pkt_out at the posedge.
// - can_load = (state==EMPTY) | (state==FULL & ~net_full).
// - src_rdy is combinational: one-hot of the selected source when can_load & |src_val, else 0.
//   It does not depend on src_pkt.
// - On a source transfer: pkt_out<=src_pkt[sel] with .valid=1, grant_id<=sel, stall_cnt<=0, state<=FULL.
//   Latency: transfer at cycle t gives pkt_out.valid at t+1.
// - No transfer but the network accepts: pkt_out.valid<=0, state<=EMPTY.
// - Simultaneous accept and transfer: the register reloads in the same cycle. Full rate is 1 pkt/cycle with no bubble.
// - FULL & net_full: pkt_out and grant_id hold stable.
//   stall_cnt increments and saturates at 2**CNT_W-1. stall_cnt is 0 in EMPTY.
// - Selection uses last = source of the previous transfer (initially none) and burst_cnt = consecutive grants to last.
//   a) Keep last if src_val[last] and (burst_cnt<MAX_BURST or no other src_val bit set).
//   b) Otherwise pick the first set src_val bit scanning rr_ptr, rr_ptr+1, ... (mod N_SRC).
// - On a transfer from sel: burst_cnt<= (sel==last) ? sat_inc(burst_cnt) : 1, and rr_ptr<=(sel+1) mod N_SRC.
//   burst_cnt saturates at MAX_BURST.
// - A sole requester is granted every load opportunity, with no forced rotation.
// - If source last drops src_val, the next grant follows rule b). burst_cnt restarts at 1 for the new source.
// - If src_val is all zero there is no transfer and the state is otherwise unchanged; last and burst_cnt are retained.
// - Sources must hold src_val and src_pkt until the transfer happens. No combinational path from src_val to pkt_out.
// STRUCTURE
// - Shared package enoc_sched_pkg: packet_t (from the ENoC config), sched_state_e {EMPTY,FULL},
//   function rr_pick(req, ptr) returning the index.
// - One sub-module enoc_rr_picker: combinational rotate-priority encoder (req[N_SRC], ptr) -> (any, idx).
//   Reused by later router arbiters.
// - Top level holds the FSM, burst/rr counters, output register and stall counter.
// TESTING
// - Single source: src_val=4'b0010, net_full=0 for 20 cycles -> 20 packets, grant_id=1 every cycle, pkt_out valid from cycle 1.
// - All request, net_full=0, MAX_BURST=8, fresh reset -> grant order src0 x8, src1 x8, src2 x8, src3 x8, then src0.
// - net_full=1 for 300 cycles with one held packet -> pkt_out stable, src_rdy=0, stall_cnt reaches 255 and holds.
//   Release gives one accept and stall_cnt=0.
// - src0 drops src_val after 3 grants while src2 requests -> next grant is src2 and burst_cnt restarts at 1.
// - rst asserted while FULL and net_full=1 -> next cycle pkt_out.valid=0, stall_cnt=0, src_rdy=0.
//   The first grant after reset is the lowest-index requester.
// - Scoreboard across a random src_val/net_full run: every accepted packet appears exactly once, in order per source.

Source files
------------

// File: rtl/enoc_sched_pkg.sv
// rtl/enoc_sched_pkg.sv - shared types and round-robin helper for the ENoC injection scheduler
package enoc_sched_pkg;

    localparam int DEST_W    = 6;
    localparam int DATA_W    = 32;
    localparam int MAX_SRC   = 16;
    localparam int MAX_SRC_W = 4;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } packet_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_e;

    // First set bit of req[0..n-1] scanning ptr, ptr+1, ... wrapping at n; 0 when none set.
    function automatic int unsigned rr_pick(input logic [MAX_SRC-1:0] req,
                                            input int unsigned ptr,
                                            input int unsigned n);
        int unsigned j;
        logic        found;
        rr_pick = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < MAX_SRC; k++) begin
            j = ptr + k;
            if (j >= n) j = j - n;
            if ((k < n) && !found && req[j[MAX_SRC_W-1:0]]) begin
                rr_pick = j;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/enoc_rr_picker.sv
// rtl/enoc_rr_picker.sv - combinational rotate-priority encoder
module enoc_rr_picker
    import enoc_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    localparam int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        any = |req;
        idx = IDX_W'(rr_pick(MAX_SRC'(req), 32'(ptr), N_SRC));
    end

endmodule

// File: rtl/enoc_inject_sched.sv
// rtl/enoc_inject_sched.sv - per-node injection scheduler: round-robin with bounded bursts
module enoc_inject_sched
    import enoc_sched_pkg::*;
#(
    parameter int N_SRC     = 4,
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 8,
    localparam int IDX_W    = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  packet_t          src_pkt [N_SRC],
    input  logic [N_SRC-1:0] src_val,
    output logic [N_SRC-1:0] src_rdy,
    input  logic             net_full,
    output packet_t          pkt_out,
    output logic [IDX_W-1:0] grant_id,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              BW        = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    sched_state_e     state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] last;
    logic             last_vld;
    logic [BW-1:0]    burst_cnt;

    logic [N_SRC-1:0] others;
    logic             keep_last;
    logic             can_load;
    logic             xfer;
    logic             pick_any;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] sel;
    packet_t          load_pkt;

    enoc_rr_picker #(.N_SRC(N_SRC)) u_picker (
        .req (src_val),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The burst limit only bites when some other source is actually waiting.
    always_comb begin
        others    = src_val & ~(N_SRC'(1) << last);
        keep_last = last_vld & src_val[last] & ((burst_cnt < BURST_MAX) | ~(|others));
        sel       = keep_last ? last : pick_idx;
        can_load  = (state == EMPTY) | ~net_full;
        xfer      = ~rst & can_load & pick_any;
        src_rdy   = xfer ? (N_SRC'(1) << sel) : '0;
        load_pkt       = src_pkt[sel];
        load_pkt.valid = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            pkt_out   <= '0;
            grant_id  <= '0;
            stall_cnt <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            last      <= '0;
            last_vld  <= 1'b0;
        end else if (xfer) begin
            state     <= FULL;
            pkt_out   <= load_pkt;
            grant_id  <= sel;
            stall_cnt <= '0;
            last      <= sel;
            last_vld  <= 1'b1;
            if (last_vld && (sel == last))
                burst_cnt <= (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 1'b1;
            else
                burst_cnt <= BW'(1);
            rr_ptr <= (sel == IDX_W'(N_SRC - 1)) ? '0 : sel + 1'b1;
        end else if (state == FULL) begin
            if (!net_full) begin
                state         <= EMPTY;
                pkt_out.valid <= 1'b0;
                stall_cnt     <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_enoc_inject_sched.sv
// tb/tb_enoc_inject_sched.sv - randomized scoreboard bench for enoc_inject_sched
module tb_enoc_inject_sched;
    import enoc_sched_pkg::*;

    localparam int N         = 4;
    localparam int MAX_BURST = 8;
    localparam int CNT_W     = 8;
    localparam int STALL_SAT = (1 << CNT_W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    packet_t      src_pkt [N];
    logic [N-1:0] src_val = '0;
    logic [N-1:0] src_rdy;
    logic         net_full = 1'b0;
    packet_t      pkt_out;
    logic [1:0]   grant_id;
    logic [CNT_W-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    logic [N-1:0] last_xfer = '0;
    int           quota [N];
    int           seq   [N];
    int           pct = 100;
    int           gnt_log [$];
    packet_t      exp_q [$];
    logic [1:0]   exp_gid_q [$];
    logic         sb_en = 1'b0;

    enoc_inject_sched #(.N_SRC(N), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_pkt   (src_pkt),
        .src_val   (src_val),
        .src_rdy   (src_rdy),
        .net_full  (net_full),
        .pkt_out   (pkt_out),
        .grant_id  (grant_id),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference model: register contents and arbitration state, stepped on every negedge.
    initial begin
        logic         m_init  = 1'b0;
        logic         m_full  = 1'b0;
        packet_t      m_pkt   = '0;
        int           m_gid   = 0;
        int           m_stall = 0;
        int           m_ptr   = 0;
        int           m_burst = 0;
        int           m_last  = -1;
        forever begin
            @(negedge clk);
            last_xfer = src_val & src_rdy;
            if (rst) begin
                check("rdy_in_reset", 64'(src_rdy), 64'(0));
                m_init = 1'b1; m_full = 1'b0; m_pkt = '0; m_gid = 0; m_stall = 0;
                m_ptr = 0; m_burst = 0; m_last = -1;
                exp_q.delete();
                exp_gid_q.delete();
            end else if (m_init) begin
                logic [N-1:0] others;
                logic [N-1:0] exp_rdy;
                logic         can;
                int           sel;
                check("valid", 64'(pkt_out.valid), 64'(m_full));
                check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
                check("grant_id", 64'(grant_id), 64'(m_gid));
                if (m_full) check("pkt_out", 64'(pkt_out), 64'(m_pkt));

                can = !m_full || !net_full;
                exp_rdy = '0;
                sel = -1;
                if (can && (src_val != 0)) begin
                    others = src_val;
                    if (m_last >= 0) others[m_last] = 1'b0;
                    if (m_last >= 0 && src_val[m_last] && (m_burst < MAX_BURST || others == 0)) begin
                        sel = m_last;
                    end else begin
                        for (int k = 0; k < N; k++) begin
                            if (src_val[(m_ptr + k) % N]) begin
                                sel = (m_ptr + k) % N;
                                break;
                            end
                        end
                    end
                    exp_rdy[sel] = 1'b1;
                end
                check("src_rdy", 64'(src_rdy), 64'(exp_rdy));
                for (int i = 0; i < N; i++) if (last_xfer[i]) gnt_log.push_back(i);

                if (sel >= 0) begin
                    m_pkt = src_pkt[sel];
                    m_pkt.valid = 1'b1;
                    exp_q.push_back(m_pkt);
                    exp_gid_q.push_back(2'(sel));
                    m_full  = 1'b1;
                    m_gid   = sel;
                    m_stall = 0;
                    m_burst = (sel == m_last) ? ((m_burst < MAX_BURST) ? m_burst + 1 : m_burst) : 1;
                    m_last  = sel;
                    m_ptr   = (sel + 1) % N;
                end else if (m_full && !net_full) begin
                    m_full  = 1'b0;
                    m_stall = 0;
                end else if (m_full) begin
                    m_stall = (m_stall < STALL_SAT) ? m_stall + 1 : m_stall;
                end
            end
        end
    end

    // Scoreboard monitor: every packet the network takes must be the oldest one issued.
    initial begin
        forever begin
            @(negedge clk);
            if (sb_en && !rst && pkt_out.valid && !net_full) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pkt", 64'(pkt_out), 64'(0));
                end else begin
                    check("sb_pkt", 64'(pkt_out), 64'(exp_q.pop_front()));
                    check("sb_gid", 64'(grant_id), 64'(exp_gid_q.pop_front()));
                end
            end
        end
    end

    task automatic advance();
        for (int i = 0; i < N; i++) begin
            if (last_xfer[i]) begin
                seq[i]++;
                src_val[i] = 1'b0;
                if (quota[i] > 0) quota[i]--;
            end
            if (!src_val[i] && quota[i] > 0 && $urandom_range(99) < pct) begin
                src_val[i]       = 1'b1;
                src_pkt[i].valid = 1'($urandom_range(1));
                src_pkt[i].dest  = 6'(i);
                src_pkt[i].data  = $urandom;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_val = '0;
        net_full = 1'b0;
        for (int i = 0; i < N; i++) quota[i] = 0;
        repeat (2) tick();
        rst = 1'b0;
        gnt_log.delete();
        sb_en = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string name);
        int budget = 60;
        while (gnt_log.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        check(name, 64'(gnt_log.size() >= n), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_pkt[i] = '0;
            seq[i] = 0;
            quota[i] = 0;
        end

        // Sole requester is granted every cycle.
        do_reset();
        quota[1] = 1000; pct = 100;
        tick();
        repeat (20) tick();
        check("single_count", 64'(gnt_log.size()), 64'(20));
        for (int k = 0; k < gnt_log.size(); k++) check("single_id", 64'(gnt_log[k]), 64'(1));

        // All sources requesting: bursts of MAX_BURST in index order.
        do_reset();
        for (int i = 0; i < N; i++) quota[i] = 1000;
        tick();
        repeat (33) tick();
        check("burst_count", 64'(gnt_log.size()), 64'(33));
        for (int k = 0; k < 33 && k < gnt_log.size(); k++)
            check("burst_order", 64'(gnt_log[k]), 64'((k < 32) ? k / 8 : 0));

        // Long backpressure: stall counter saturates, nothing is granted.
        do_reset();
        quota[0] = 1000;
        net_full = 1'b1;
        tick();
        repeat (300) tick();
        @(negedge clk);
        check("stall_sat", 64'(stall_cnt), 64'(STALL_SAT));
        check("stall_rdy", 64'(src_rdy), 64'(0));
        check("stall_valid", 64'(pkt_out.valid), 64'(1));
        check("stall_gid", 64'(grant_id), 64'(0));
        tick();
        quota[0] = 0;
        net_full = 1'b0;
        tick();
        @(negedge clk);
        check("release_stall", 64'(stall_cnt), 64'(0));
        check("release_grants", 64'(gnt_log.size()), 64'(2));

        // Burst source drops out after three grants; the waiting source takes over.
        do_reset();
        quota[0] = 3; quota[2] = 1000;
        tick();
        wait_grants(4, "drop_wait");
        if (gnt_log.size() >= 4) begin
            check("drop_g0", 64'(gnt_log[0]), 64'(0));
            check("drop_g1", 64'(gnt_log[1]), 64'(0));
            check("drop_g2", 64'(gnt_log[2]), 64'(0));
            check("drop_g3", 64'(gnt_log[3]), 64'(2));
        end

        // Reset while holding a stalled packet.
        do_reset();
        quota[3] = 1;
        net_full = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("rst_valid", 64'(pkt_out.valid), 64'(0));
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_rdy", 64'(src_rdy), 64'(0));
        tick();
        rst = 1'b0;
        net_full = 1'b0;
        gnt_log.delete();
        quota[1] = 1; quota[3] = 1;
        tick();
        wait_grants(1, "rst_wait");
        if (gnt_log.size() >= 1) check("rst_first_grant", 64'(gnt_log[0]), 64'(1));

        // Random requests and backpressure, then drain.
        do_reset();
        for (int i = 0; i < N; i++) quota[i] = 1000000;
        pct = 50;
        repeat (3000) begin
            net_full = ($urandom_range(99) < 30);
            tick();
        end
        for (int i = 0; i < N; i++) quota[i] = 0;
        net_full = 1'b0;
        repeat (20) tick();
        check("drain_queue", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        check("drain_valid", 64'(pkt_out.valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule
